// File: rtl/hdcp_tx_ctl.sv
// rtl/hdcp_tx_ctl.sv - HDCP transmit link controller: cipher sequencing, pixel encryption, vsync control codes
module hdcp_tx_ctl #(
   parameter int CTL_OFFSET = 8,
   parameter int CTL_LEN    = 16,
   parameter int CNT_W      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        link_lost,
   input  logic        auth_start,
   input  logic        encrypt_req,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [23:0] pix_in,
   output logic        cipher_init,
   output logic        cipher_auth,
   output logic        cipher_rekey,
   output logic        cipher_stream_ena,
   input  logic [23:0] cipher_stream,
   input  logic        cipher_ready,
   output logic [23:0] pix_out,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [3:0]  ctl_code_out,
   output logic        authenticated,
   output logic        enc_active
);

   typedef enum logic [3:0] {
      IDLE, AUTH_PULSE, AUTH_WAIT, WAIT_VSYNC,
      FRAME_INIT_PULSE, FRAME_INIT_WAIT, READY, REKEY_WAIT
   } state_t;

   localparam logic [CNT_W:0] WIN_LO = (CNT_W+1)'(CTL_OFFSET);
   localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(CTL_OFFSET + CTL_LEN);

   state_t           state;
   logic             vsync_d, de_d, seen_low, vsync_pend, enc_frame;
   logic [CNT_W-1:0] win_cnt;

   logic             vsync_rise, de_fall, auth_st, enc_ok, ready_ok, in_win, enc_now;
   logic [CNT_W-1:0] cnt_cur;

   assign vsync_rise = vsync & ~vsync_d;
   assign de_fall    = ~de & de_d;
   assign auth_st    = state inside {FRAME_INIT_PULSE, FRAME_INIT_WAIT, READY, REKEY_WAIT};
   assign enc_ok     = encrypt_req &
                       (state inside {READY, REKEY_WAIT, WAIT_VSYNC, FRAME_INIT_PULSE, FRAME_INIT_WAIT});
   // Cipher handshakes complete only after ready has been observed low since the request.
   assign ready_ok   = cipher_ready & seen_low;
   // The rise cycle itself is window position 0; the stored count lags by one.
   assign cnt_cur    = vsync_rise ? '0 : win_cnt;
   assign in_win     = ({1'b0, cnt_cur} >= WIN_LO) && ({1'b0, cnt_cur} < WIN_HI);
   assign enc_now    = vsync_rise ? enc_ok : enc_frame;

   assign cipher_stream_ena = de & enc_frame & (state == READY);
   assign enc_active        = enc_frame;

   always_ff @(posedge clk) begin
      if (rst || link_lost) begin
         state         <= IDLE;
         vsync_d       <= 1'b0;
         de_d          <= 1'b0;
         seen_low      <= 1'b0;
         vsync_pend    <= 1'b0;
         enc_frame     <= 1'b0;
         win_cnt       <= '0;
         cipher_init   <= 1'b0;
         cipher_auth   <= 1'b0;
         cipher_rekey  <= 1'b0;
         pix_out       <= '0;
         de_out        <= 1'b0;
         hsync_out     <= 1'b0;
         vsync_out     <= 1'b0;
         ctl_code_out  <= 4'b0000;
         authenticated <= 1'b0;
      end else begin
         vsync_d   <= vsync;
         de_d      <= de;
         de_out    <= de;
         hsync_out <= hsync;
         vsync_out <= vsync;
         pix_out   <= cipher_stream_ena ? (pix_in ^ cipher_stream) : pix_in;

         if (vsync_rise) enc_frame <= enc_ok;
         if (vsync) win_cnt <= (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;

         if (in_win && vsync && !de)
            ctl_code_out <= enc_now ? 4'b1001 : (auth_st ? 4'b0001 : 4'b0000);
         else
            ctl_code_out <= 4'b0000;

         cipher_init   <= (state == AUTH_PULSE) || (state == FRAME_INIT_PULSE);
         cipher_auth   <= (state == AUTH_PULSE);
         authenticated <= auth_st;
         cipher_rekey  <= 1'b0;

         if ((state inside {AUTH_WAIT, FRAME_INIT_WAIT, REKEY_WAIT}) && !cipher_ready)
            seen_low <= 1'b1;

         if (auth_start) begin
            state <= AUTH_PULSE;
         end else begin
            case (state)
               IDLE: ;
               AUTH_PULSE: begin
                  seen_low <= 1'b0;
                  state    <= AUTH_WAIT;
               end
               AUTH_WAIT:
                  if (ready_ok) state <= WAIT_VSYNC;
               WAIT_VSYNC:
                  if (vsync_rise) state <= FRAME_INIT_PULSE;
               FRAME_INIT_PULSE: begin
                  seen_low   <= 1'b0;
                  vsync_pend <= 1'b0;
                  state      <= FRAME_INIT_WAIT;
               end
               FRAME_INIT_WAIT:
                  if (ready_ok) state <= READY;
               READY: begin
                  if (vsync_rise) begin
                     state <= FRAME_INIT_PULSE;
                  end else if (de_fall) begin
                     cipher_rekey <= 1'b1;
                     seen_low     <= 1'b0;
                     state        <= REKEY_WAIT;
                  end else if (!cipher_ready) begin
                     // Cipher dropped ready on its own; its low phase is already seen.
                     seen_low <= 1'b1;
                     state    <= REKEY_WAIT;
                  end
               end
               REKEY_WAIT: begin
                  if (vsync_rise) vsync_pend <= 1'b1;
                  if (ready_ok)
                     state <= (vsync_pend || vsync_rise) ? FRAME_INIT_PULSE : READY;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hdcp_tx_ctl.sv
// tb/tb_hdcp_tx_ctl.sv - directed, table-driven bench for hdcp_tx_ctl
module tb_hdcp_tx_ctl;

   logic        clk = 1'b0;
   logic        rst, link_lost, auth_start, encrypt_req, de, hsync, vsync;
   logic [23:0] pix_in, cipher_stream;
   logic        cipher_ready;
   logic        cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena;
   logic [23:0] pix_out;
   logic        de_out, hsync_out, vsync_out, authenticated, enc_active;
   logic [3:0]  ctl_code_out;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   hdcp_tx_ctl #(.CTL_OFFSET(8), .CTL_LEN(16), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .link_lost(link_lost), .auth_start(auth_start),
      .encrypt_req(encrypt_req), .de(de), .hsync(hsync), .vsync(vsync), .pix_in(pix_in),
      .cipher_init(cipher_init), .cipher_auth(cipher_auth), .cipher_rekey(cipher_rekey),
      .cipher_stream_ena(cipher_stream_ena), .cipher_stream(cipher_stream),
      .cipher_ready(cipher_ready), .pix_out(pix_out), .de_out(de_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .ctl_code_out(ctl_code_out),
      .authenticated(authenticated), .enc_active(enc_active)
   );

   typedef struct {
      logic        de;
      logic        hs;
      logic [23:0] pix;
      logic [23:0] cs;
      logic        exp_ena;
      logic [23:0] exp_pix;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Authenticate from IDLE/READY; cipher_ready drops for two cycles.
   task automatic do_auth();
      int ni, na;
      ni = 0;
      na = 0;
      step();
      auth_start   = 1'b1;
      cipher_ready = 1'b1;
      for (int k = 1; k < 10; k++) begin
         step();
         auth_start   = 1'b0;
         cipher_ready = !(k == 3 || k == 4);
         if (cipher_init) ni++;
         if (cipher_auth) na++;
         if (k == 2) check("auth_pulse", 32'({cipher_init, cipher_auth}), 32'h3);
      end
      check("auth_init_count", 32'(ni), 32'd1);
      check("auth_auth_count", 32'(na), 32'd1);
      check("auth_not_yet", 32'(authenticated), 32'd0);
   endtask

   // One vsync frame: rise at k=0, vsync high for 30 cycles, de low; encrypt_req flips at k=10.
   task automatic run_frame(input logic enc, input logic [3:0] code, input int init_k,
                            input logic [31:0] low_mask);
      for (int k = 0; k < 32; k++) begin
         step();
         vsync        = (k < 30);
         de           = 1'b0;
         encrypt_req  = (k < 10) ? enc : ~enc;
         cipher_ready = ~low_mask[k];
         check($sformatf("ctl_k%0d", k), 32'(ctl_code_out),
               32'((k >= 9 && k <= 24) ? code : 4'b0000));
         check($sformatf("init_k%0d", k), 32'(cipher_init), 32'(k == init_k));
         if (k >= 1) check($sformatf("rekey_k%0d", k), 32'(cipher_rekey), 32'd0);
         if (k == init_k) check("frame_init_noauth", 32'(cipher_auth), 32'd0);
         if (k == 2) check("enc_active", 32'(enc_active), 32'(enc));
      end
   endtask

   initial begin
      tbl[0] = '{de: 1'b1, hs: 1'b0, pix: 24'h000000, cs: 24'hA5A5A5, exp_ena: 1'b1, exp_pix: 24'hA5A5A5};
      tbl[1] = '{de: 1'b1, hs: 1'b1, pix: 24'h123456, cs: 24'hFFFFFF, exp_ena: 1'b1, exp_pix: 24'hEDCBA9};
      tbl[2] = '{de: 1'b1, hs: 1'b0, pix: 24'hABCDEF, cs: 24'h000000, exp_ena: 1'b1, exp_pix: 24'hABCDEF};
      tbl[3] = '{de: 1'b1, hs: 1'b1, pix: 24'hFFFFFF, cs: 24'h0F0F0F, exp_ena: 1'b1, exp_pix: 24'hF0F0F0};
      tbl[4] = '{de: 1'b0, hs: 1'b0, pix: 24'h555555, cs: 24'h777777, exp_ena: 1'b0, exp_pix: 24'h555555};

      rst = 1'b1; link_lost = 1'b0; auth_start = 1'b0; encrypt_req = 1'b0;
      de = 1'b1; hsync = 1'b1; vsync = 1'b1; pix_in = 24'hFFFFFF;
      cipher_stream = 24'h0; cipher_ready = 1'b1;
      repeat (3) step();
      check("rst_pix", 32'(pix_out), 32'h0);
      check("rst_timing", 32'({de_out, hsync_out, vsync_out}), 32'h0);
      check("rst_ctl", 32'(ctl_code_out), 32'h0);
      check("rst_auth", 32'(authenticated), 32'h0);
      check("rst_enc", 32'(enc_active), 32'h0);
      check("rst_cipher", 32'({cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena}), 32'h0);
      rst = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; pix_in = 24'h0;

      do_auth();
      run_frame(1'b1, 4'b1001, 2, 32'h18);

      // Encrypted active line, ending in a de fall
      for (int i = 0; i < 5; i++) begin
         step();
         if (i > 0) begin
            check($sformatf("tbl_pix%0d", i - 1), 32'(pix_out), 32'(tbl[i-1].exp_pix));
            check($sformatf("tbl_de%0d", i - 1), 32'(de_out), 32'(tbl[i-1].de));
            check($sformatf("tbl_hs%0d", i - 1), 32'(hsync_out), 32'(tbl[i-1].hs));
         end
         de = tbl[i].de; hsync = tbl[i].hs; pix_in = tbl[i].pix; cipher_stream = tbl[i].cs;
         #1;
         check($sformatf("tbl_ena%0d", i), 32'(cipher_stream_ena), 32'(tbl[i].exp_ena));
      end
      step();
      check("tbl_pix4", 32'(pix_out), 32'h555555);
      check("rekey_pulse", 32'(cipher_rekey), 32'd1);
      de = 1'b1; pix_in = 24'h111111; cipher_stream = 24'h222222; cipher_ready = 1'b1;
      #1 check("rekey_wait_ena0", 32'(cipher_stream_ena), 32'd0);
      step();
      check("rekey_wait_pix", 32'(pix_out), 32'h111111);
      check("rekey_single", 32'(cipher_rekey), 32'd0);
      cipher_ready = 1'b0;
      #1 check("rekey_wait_ena1", 32'(cipher_stream_ena), 32'd0);
      step();
      cipher_ready = 1'b1;
      #1 check("rekey_wait_ena2", 32'(cipher_stream_ena), 32'd0);
      step();
      pix_in = 24'h000000; cipher_stream = 24'h00000F;
      #1 check("ready_again_ena", 32'(cipher_stream_ena), 32'd1);
      step();
      check("ready_again_pix", 32'(pix_out), 32'h00000F);
      de = 1'b0;

      // vsync rise while waiting on the rekey; frame is plaintext
      run_frame(1'b0, 4'b0001, 4, 32'h22);

      for (int j = 0; j < 4; j++) begin
         step();
         if (j > 0) check($sformatf("plain_pix%0d", j), 32'(pix_out), 32'(pix_in));
         de = 1'b1; pix_in = {8'(j), 16'hBEEF}; cipher_stream = 24'hFFFFFF;
         #1 check($sformatf("plain_ena%0d", j), 32'(cipher_stream_ena), 32'd0);
      end

      // de fall coincident with vsync rise in READY
      run_frame(1'b1, 4'b1001, 2, 32'h18);

      for (int j = 0; j < 3; j++) begin
         step();
         if (j > 0) check($sformatf("enc_pix%0d", j), 32'(pix_out), 32'h00FFFF);
         de = 1'b1; pix_in = 24'h00FF00; cipher_stream = 24'h0000FF;
         #1 check($sformatf("enc_ena%0d", j), 32'(cipher_stream_ena), 32'd1);
      end
      step();
      link_lost = 1'b1;
      step();
      link_lost = 1'b0; pix_in = 24'hABCDEF;
      check("lost_pix", 32'(pix_out), 32'h0);
      check("lost_timing", 32'({de_out, hsync_out, vsync_out}), 32'h0);
      check("lost_auth", 32'(authenticated), 32'h0);
      check("lost_enc", 32'(enc_active), 32'h0);
      check("lost_ctl", 32'(ctl_code_out), 32'h0);
      #1 check("lost_ena", 32'(cipher_stream_ena), 32'd0);
      step();
      check("idle_pix", 32'(pix_out), 32'hABCDEF);
      de = 1'b0;

      do_auth();
      run_frame(1'b1, 4'b1001, 2, 32'h18);
      step();
      auth_start = 1'b1;
      step();
      auth_start = 1'b0;
      check("reauth_was_auth", 32'(authenticated), 32'd1);
      step();
      check("reauth_pulse", 32'({cipher_init, cipher_auth}), 32'h3);
      check("reauth_deauth", 32'(authenticated), 32'd0);
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
